// File: rtl/pmod_cls_text_spi_multi_pkg.sv
// Shared types and escape-sequence constants for the PMOD CLS multi-line driver.
package pmod_cls_multi_pkg;

   typedef enum logic [1:0] {
      CLS_CLEAR      = 2'd0,
      CLS_WRITE      = 2'd1,
      CLS_CURSOR_OFF = 2'd2,
      CLS_RSVD       = 2'd3
   } t_cls_op;

   typedef logic [7:0] t_pmod_cls_data_byte;
   typedef logic [7:0] t_pmod_cls_tx_len;

   localparam t_pmod_cls_data_byte c_asc_esc    = 8'h1B;
   localparam t_pmod_cls_data_byte c_asc_lbrack = 8'h5B;
   localparam t_pmod_cls_data_byte c_asc_semi   = 8'h3B;
   localparam t_pmod_cls_data_byte c_asc_0      = 8'h30;
   localparam t_pmod_cls_data_byte c_asc_j      = 8'h6A;
   localparam t_pmod_cls_data_byte c_asc_c      = 8'h63;
   localparam t_pmod_cls_data_byte c_asc_h      = 8'h48;

   localparam t_pmod_cls_tx_len c_cls_pos_seq_len   = 8'd7;
   localparam t_pmod_cls_tx_len c_cls_short_seq_len = 8'd4;

   // Short sequences are left-aligned in the 56-bit shift register
   localparam logic [55:0] c_cls_clear_seq =
      {c_asc_esc, c_asc_lbrack, c_asc_0, c_asc_j, 24'h0};
   localparam logic [55:0] c_cls_curoff_seq =
      {c_asc_esc, c_asc_lbrack, c_asc_0, c_asc_c, 24'h0};

endpackage

// File: rtl/pmod_cls_text_spi_multi_pos_encoder.sv
// Row/column to 7-byte cursor-position escape sequence (ESC [ r ; t o H).
module pmod_cls_pos_encoder
   import pmod_cls_multi_pkg::*;
(
   input  logic [1:0]  i_row,
   input  logic [5:0]  i_col,
   output logic [55:0] o_seq
);

   logic [5:0] w_tens;
   logic [5:0] w_ones;

   assign w_tens = i_col / 6'd10;
   assign w_ones = i_col % 6'd10;

   assign o_seq = {
      c_asc_esc,
      c_asc_lbrack,
      c_asc_0 + {6'd0, i_row},
      c_asc_semi,
      c_asc_0 + {2'd0, w_tens},
      c_asc_0 + {2'd0, w_ones},
      c_asc_h
   };

endmodule

// File: rtl/pmod_cls_text_spi_multi.sv
// PMOD CLS text driver (LINES x COLS) feeding a standard-SPI solo engine.
// Optional boot-time CLEAR + CURSOR_OFF via macro PMOD_CLS_BOOT_INIT_EN.
module pmod_cls_text_spi_multi
   import pmod_cls_multi_pkg::*;
#(
   parameter int parm_fast_simulation = 0,
   parameter int FCLK                 = 20000000,
   parameter int FCLK_ce              = 2500000,
   parameter int LINES                = 2,
   parameter int COLS                 = 16
) (
   input  logic              i_ext_spi_clk_x,
   input  logic              i_srst_n,
   input  logic              i_spi_ce_4x,
   output logic              o_go_stand,
   input  logic              i_spi_idle,
   output logic [7:0]        o_tx_len,
   output logic [7:0]        o_wait_cyc,
   output logic [7:0]        o_rx_len,
   output logic [7:0]        o_tx_data,
   output logic              o_tx_enqueue,
   input  logic              i_tx_ready,
   output logic              o_rx_dequeue,
   input  logic              i_cmd_valid,
   output logic              o_cmd_ready,
   input  logic [1:0]        i_cmd_op,
   input  logic [1:0]        i_cmd_row,
   input  logic [5:0]        i_cmd_col,
   input  logic [5:0]        i_cmd_len,
   input  logic [8*COLS-1:0] i_cmd_text,
   output logic              o_cmd_done,
   output logic              o_cmd_err
);

   localparam int c_boot_max = (parm_fast_simulation != 0) ?
      (FCLK_ce / 1000 * 2 - 1) : (FCLK_ce / 1000 * 800 - 1);
   localparam int c_tw = 8 * COLS;

   localparam logic [2:0] S_BOOT     = 3'd0;
   localparam logic [2:0] S_IDLE     = 3'd1;
   localparam logic [2:0] S_CMD_RUN  = 3'd2;
   localparam logic [2:0] S_CMD_WAIT = 3'd3;
   localparam logic [2:0] S_DAT_RUN  = 3'd4;
   localparam logic [2:0] S_DAT_WAIT = 3'd5;

   logic [2:0]       r_state;
   logic [31:0]      r_boot_cnt;
   t_cls_op          r_op;
   logic [55:0]      r_seq;
   logic [c_tw-1:0]  r_text;
   t_pmod_cls_tx_len r_tot;
   t_pmod_cls_tx_len r_rem;
   t_pmod_cls_tx_len r_dlen;
   logic             r_done;
   logic             r_err;
   logic [1:0]       r_init;

   t_cls_op     w_op;
   logic [55:0] w_pos;
   logic [6:0]  w_room;
   logic [6:0]  w_len;
   logic [6:0]  w_eff;
   logic        w_bad;
   logic        w_run;
   logic        w_enq;

   pmod_cls_pos_encoder u_pos (
      .i_row (i_cmd_row),
      .i_col (i_cmd_col),
      .o_seq (w_pos)
   );

   assign w_op   = t_cls_op'(i_cmd_op);
   assign w_room = 7'(COLS) - {1'b0, i_cmd_col};
   assign w_len  = {1'b0, i_cmd_len};
   assign w_eff  = (w_len < w_room) ? w_len : w_room;
   assign w_bad  = (w_op == CLS_RSVD) ||
                   ({30'd0, i_cmd_row} >= 32'(LINES)) ||
                   ({26'd0, i_cmd_col} >= 32'(COLS));

   assign w_run = (r_state == S_CMD_RUN) || (r_state == S_DAT_RUN);
   assign w_enq = w_run && i_tx_ready && i_spi_ce_4x;

   assign o_tx_enqueue = w_enq;
   assign o_go_stand   = w_enq && (r_rem == 8'd1);
   assign o_tx_len     = (r_state >= S_CMD_RUN) ? r_tot : 8'd0;
   assign o_tx_data    = (r_state == S_CMD_RUN) ? r_seq[55:48] :
                         (r_state == S_DAT_RUN) ? r_text[c_tw-1 -: 8] : 8'd0;
   assign o_wait_cyc   = 8'd0;
   assign o_rx_len     = 8'd0;
   assign o_rx_dequeue = 1'b0;
   assign o_cmd_ready  = (r_state == S_IDLE);
   assign o_cmd_done   = r_done;
   assign o_cmd_err    = r_err;

   always_ff @(posedge i_ext_spi_clk_x) begin
      if (!i_srst_n) begin
         r_state    <= S_BOOT;
         r_boot_cnt <= '0;
         r_op       <= CLS_CLEAR;
         r_seq      <= '0;
         r_text     <= '0;
         r_tot      <= '0;
         r_rem      <= '0;
         r_dlen     <= '0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_init     <= 2'd0;
      end else if (i_spi_ce_4x) begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            S_BOOT: begin
               if (r_boot_cnt == 32'(c_boot_max)) begin
`ifdef PMOD_CLS_BOOT_INIT_EN
                  r_op    <= CLS_CLEAR;
                  r_seq   <= c_cls_clear_seq;
                  r_tot   <= c_cls_short_seq_len;
                  r_rem   <= c_cls_short_seq_len;
                  r_init  <= 2'd1;
                  r_state <= S_CMD_RUN;
`else
                  r_state <= S_IDLE;
`endif
               end else begin
                  r_boot_cnt <= r_boot_cnt + 32'd1;
               end
            end
            S_IDLE: begin
               if (i_cmd_valid) begin
                  if (w_bad) begin
                     r_err <= 1'b1;
                  end else if (w_op == CLS_WRITE && w_eff == 7'd0) begin
                     r_done <= 1'b1;
                  end else begin
                     r_op    <= w_op;
                     r_text  <= i_cmd_text;
                     r_dlen  <= {1'b0, w_eff};
                     r_state <= S_CMD_RUN;
                     if (w_op == CLS_WRITE) begin
                        r_seq <= w_pos;
                        r_tot <= c_cls_pos_seq_len;
                        r_rem <= c_cls_pos_seq_len;
                     end else begin
                        r_seq <= (w_op == CLS_CLEAR) ?
                                 c_cls_clear_seq : c_cls_curoff_seq;
                        r_tot <= c_cls_short_seq_len;
                        r_rem <= c_cls_short_seq_len;
                     end
                  end
               end
            end
            S_CMD_RUN: begin
               if (i_tx_ready) begin
                  r_seq <= r_seq << 8;
                  r_rem <= r_rem - 8'd1;
                  if (r_rem == 8'd1) r_state <= S_CMD_WAIT;
               end
            end
            S_CMD_WAIT: begin
               if (i_spi_idle) begin
                  // INIT chain: CLEAR then CURSOR_OFF, silent return to IDLE
                  if (r_init == 2'd1) begin
                     r_op    <= CLS_CURSOR_OFF;
                     r_seq   <= c_cls_curoff_seq;
                     r_tot   <= c_cls_short_seq_len;
                     r_rem   <= c_cls_short_seq_len;
                     r_init  <= 2'd2;
                     r_state <= S_CMD_RUN;
                  end else if (r_init == 2'd2) begin
                     r_init  <= 2'd0;
                     r_state <= S_IDLE;
                  end else if (r_op == CLS_WRITE) begin
                     r_tot   <= r_dlen;
                     r_rem   <= r_dlen;
                     r_state <= S_DAT_RUN;
                  end else begin
                     r_done  <= 1'b1;
                     r_state <= S_IDLE;
                  end
               end
            end
            S_DAT_RUN: begin
               if (i_tx_ready) begin
                  r_text <= r_text << 8;
                  r_rem  <= r_rem - 8'd1;
                  if (r_rem == 8'd1) r_state <= S_DAT_WAIT;
               end
            end
            S_DAT_WAIT: begin
               if (i_spi_idle) begin
                  r_done  <= 1'b1;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_BOOT;
         endcase
      end
   end

endmodule

// File: tb/tb_pmod_cls_text_spi_multi.sv
// Directed bench for pmod_cls_text_spi_multi; geometry follows PMOD_CLS_BOOT_INIT_EN.
module tb_pmod_cls_text_spi_multi;

`ifdef PMOD_CLS_BOOT_INIT_EN
   localparam int LINES = 4;
   localparam int COLS  = 40;
`else
   localparam int LINES = 2;
   localparam int COLS  = 16;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              i_srst_n;
   logic              i_spi_ce_4x;
   logic              o_go_stand;
   logic              i_spi_idle;
   logic [7:0]        o_tx_len;
   logic [7:0]        o_wait_cyc;
   logic [7:0]        o_rx_len;
   logic [7:0]        o_tx_data;
   logic              o_tx_enqueue;
   logic              i_tx_ready;
   logic              o_rx_dequeue;
   logic              i_cmd_valid;
   logic              o_cmd_ready;
   logic [1:0]        i_cmd_op;
   logic [1:0]        i_cmd_row;
   logic [5:0]        i_cmd_col;
   logic [5:0]        i_cmd_len;
   logic [8*COLS-1:0] i_cmd_text;
   logic              o_cmd_done;
   logic              o_cmd_err;

   logic [8*COLS-1:0] txt;
   int n_vec = 0;
   int n_err = 0;

   pmod_cls_text_spi_multi #(
      .parm_fast_simulation (1),
      .FCLK                 (20000000),
      .FCLK_ce              (2500000),
      .LINES                (LINES),
      .COLS                 (COLS)
   ) dut (
      .i_ext_spi_clk_x (clk),
      .i_srst_n        (i_srst_n),
      .i_spi_ce_4x     (i_spi_ce_4x),
      .o_go_stand      (o_go_stand),
      .i_spi_idle      (i_spi_idle),
      .o_tx_len        (o_tx_len),
      .o_wait_cyc      (o_wait_cyc),
      .o_rx_len        (o_rx_len),
      .o_tx_data       (o_tx_data),
      .o_tx_enqueue    (o_tx_enqueue),
      .i_tx_ready      (i_tx_ready),
      .o_rx_dequeue    (o_rx_dequeue),
      .i_cmd_valid     (i_cmd_valid),
      .o_cmd_ready     (o_cmd_ready),
      .i_cmd_op        (i_cmd_op),
      .i_cmd_row       (i_cmd_row),
      .i_cmd_col       (i_cmd_col),
      .i_cmd_len       (i_cmd_len),
      .i_cmd_text      (i_cmd_text),
      .o_cmd_done      (o_cmd_done),
      .o_cmd_err       (o_cmd_err)
   );

   function automatic logic [37:0] all_outs();
      return {o_go_stand, o_tx_enqueue, o_tx_len, o_tx_data, o_wait_cyc,
              o_rx_len, o_rx_dequeue, o_cmd_ready, o_cmd_done, o_cmd_err};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Drains one SPI operation, acting as FIFO and engine
   task automatic capture(input string tag, input int n,
                          input logic [55:0] exp, input bit toggle);
      int got = 0;
      bit gone = 1'b0;
      logic [55:0] sh = exp;
      for (int cyc = 0; cyc < 200 && !gone; cyc++) begin
         i_tx_ready = toggle ? ~i_tx_ready : 1'b1;
         #1;
         if (o_tx_enqueue) begin
            check({tag, "_len"}, o_tx_len, 64'(n));
            check({tag, "_byte"}, o_tx_data, sh[55:48]);
            check({tag, "_go"}, o_go_stand, (got == n - 1));
            sh = sh << 8;
            got++;
            gone = o_go_stand;
         end else if (o_go_stand) begin
            check({tag, "_stallgo"}, o_go_stand, 0);
         end
         if (gone) i_spi_idle = 1'b0;
         tick();
      end
      check({tag, "_count"}, got, 64'(n));
      tick();
      tick();
      check({tag, "_hold"}, o_tx_enqueue, 0);
      i_spi_idle = 1'b1;
   endtask

   task automatic wait_done(input string tag);
      bit seen = 1'b0;
      for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
         if (o_cmd_done) seen = 1'b1;
         else tick();
      end
      check({tag, "_done"}, seen, 1);
      tick();
      check({tag, "_done1"}, o_cmd_done, 0);
   endtask

   task automatic issue(input logic [1:0] op, input logic [1:0] row,
                        input logic [5:0] col, input logic [5:0] len);
      i_cmd_op    = op;
      i_cmd_row   = row;
      i_cmd_col   = col;
      i_cmd_len   = len;
      i_cmd_text  = txt;
      i_cmd_valid = 1'b1;
      #1;
      check("ready_pre", o_cmd_ready, 1);
      tick();
      i_cmd_valid = 1'b0;
      i_cmd_op    = 2'd3;
      i_cmd_row   = 2'd3;
      i_cmd_col   = 6'd63;
      i_cmd_len   = 6'd63;
      i_cmd_text  = '1;
   endtask

   task automatic reject(input string tag, input logic [1:0] op,
                         input logic [1:0] row, input logic [5:0] col);
      issue(op, row, col, 6'd4);
      check({tag, "_err"}, o_cmd_err, 1);
      check({tag, "_enq"}, o_tx_enqueue, 0);
      check({tag, "_rdy"}, o_cmd_ready, 1);
      tick();
      check({tag, "_err1"}, o_cmd_err, 0);
      check({tag, "_len0"}, o_tx_len, 0);
   endtask

   task automatic boot();
      int early = 0;
      for (int i = 0; i < 4999; i++) begin
         tick();
         early += int'(o_tx_enqueue | o_go_stand | o_cmd_ready);
      end
      check("boot_early", early, 0);
      tick();
`ifdef PMOD_CLS_BOOT_INIT_EN
      check("init_ready0", o_cmd_ready, 0);
      capture("init_clr", 4, {8'h1B, 8'h5B, 8'h30, 8'h6A, 24'h0}, 1'b0);
      check("init_ready1", o_cmd_ready, 0);
      capture("init_coff", 4, {8'h1B, 8'h5B, 8'h30, 8'h63, 24'h0}, 1'b0);
      tick();
      check("init_idle", o_cmd_ready, 1);
      check("init_nodone", o_cmd_done, 0);
`else
      check("boot_ready", o_cmd_ready, 1);
`endif
   endtask

   initial begin
      i_srst_n    = 1'b0;
      i_spi_ce_4x = 1'b1;
      i_spi_idle  = 1'b1;
      i_tx_ready  = 1'b1;
      i_cmd_valid = 1'b0;
      i_cmd_op    = 2'd0;
      i_cmd_row   = 2'd0;
      i_cmd_col   = 6'd0;
      i_cmd_len   = 6'd0;
      i_cmd_text  = '0;
      for (int i = 0; i < COLS; i++)
         txt[8*(COLS-1-i) +: 8] = 8'(8'h41 + i);

      repeat (3) tick();
      check("reset_outs", all_outs(), 0);
      i_srst_n = 1'b1;
      boot();

      issue(2'd0, 2'd0, 6'd0, 6'd0);
      capture("clear", 4, {8'h1B, 8'h5B, 8'h30, 8'h6A, 24'h0}, 1'b0);
      wait_done("clear");

      issue(2'd2, 2'd0, 6'd0, 6'd0);
      capture("coff", 4, {8'h1B, 8'h5B, 8'h30, 8'h63, 24'h0}, 1'b0);
      wait_done("coff");

`ifdef PMOD_CLS_BOOT_INIT_EN
      issue(2'd1, 2'd3, 6'd39, 6'd5);
      capture("wpos", 7, {8'h1B, 8'h5B, 8'h33, 8'h3B, 8'h33, 8'h39, 8'h48}, 1'b1);
      capture("wdat", 1, {8'h41, 48'h0}, 1'b1);
      wait_done("write");
      reject("rej_col", 2'd1, 2'd0, 6'd40);
      reject("rej_op", 2'd3, 2'd0, 6'd0);
`else
      issue(2'd1, 2'd1, 6'd12, 6'd8);
      capture("wpos", 7, {8'h1B, 8'h5B, 8'h31, 8'h3B, 8'h31, 8'h32, 8'h48}, 1'b1);
      capture("wdat", 4, {8'h41, 8'h42, 8'h43, 8'h44, 24'h0}, 1'b1);
      wait_done("write");
      reject("rej_row", 2'd1, 2'd2, 6'd0);
      reject("rej_col", 2'd1, 2'd0, 6'd16);
      reject("rej_op", 2'd3, 2'd0, 6'd0);
`endif

      issue(2'd1, 2'd0, 6'd3, 6'd0);
      check("len0_done", o_cmd_done, 1);
      check("len0_enq", o_tx_enqueue, 0);
      tick();
      check("len0_done1", o_cmd_done, 0);
      check("len0_idle", o_cmd_ready, 1);

      issue(2'd1, 2'd0, 6'd0, 6'd10);
      capture("rpos", 7, {8'h1B, 8'h5B, 8'h30, 8'h3B, 8'h30, 8'h30, 8'h48}, 1'b0);
      i_tx_ready = 1'b1;
      tick();
      check("rdat_len", o_tx_len, 10);
      check("rdat_b0", {o_tx_enqueue, o_tx_data}, {1'b1, 8'h41});
      tick();
      check("rdat_b1", {o_tx_enqueue, o_tx_data}, {1'b1, 8'h42});
      i_srst_n = 1'b0;
      tick();
      check("rst_mid_outs", all_outs(), 0);
      check("rst_mid_state", dut.r_state, 0);
      i_srst_n = 1'b1;
      boot();

      issue(2'd0, 2'd0, 6'd0, 6'd0);
      capture("clear2", 4, {8'h1B, 8'h5B, 8'h30, 8'h6A, 24'h0}, 1'b0);
      wait_done("clear2");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
